mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
- Multi-cycle MIPS control unit. Decodes the latched instruction's op/funct and sequences the datapath through fetch, decode, execute, memory and writeback.
- Drives the ALU's 3-bit ALUop code and consumes its zero flag for beq.
- Sits beside the datapath: IR feeds op/funct, memory returns mem_ready.
- Supported instructions: addu, subu, slt, ori, addiu, lw, sw, beq, j.

Parameters:
- MEM_TIMEOUT, 15: maximum cycles spent waiting for mem_ready in one memory state before abort. 0 disables the timeout.
- CNT_W, 4: width of the wait counter. Must hold MEM_TIMEOUT.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- op  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag (combinational, same cycle).
- mem_ready  in  1  memory access complete this cycle.
- ALUop  out  3  001 add, 010 or, 101 sub, 111 slt, 000 no-op.
- pc_wr  out  1  PC load enable.
- pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- iord  out  1  memory address source: 0 PC, 1 ALUOut.
- mem_rd, mem_wr  out  1 each  memory strobes.
- ir_wr  out  1  IR load.
- reg_dst  out  1  destination register: 0 rt, 1 rd.
- mem_to_reg  out  1  writeback source: 1 MDR.
- reg_wr  out  1  register file write.
- alu_src_a  out  1  ALU A: 0 PC, 1 A register.
- alu_src_b  out  2  ALU B: 00 B register, 01 const 4, 10 ext imm, 11 ext imm<<2.
- ext_sel  out  1  immediate extension: 1 sign, 0 zero.
- instr_done  out  1  one-cycle pulse on instruction retire.
- illegal  out  1  one-cycle pulse on unsupported op/funct.
- bus_err  out  1  one-cycle pulse on memory timeout.

Behaviour:
- Reset: rst_n low → state FETCH, wait counter 0, all outputs 0 (ALUop=000), asynchronously and mid-instruction included. No partial write completes. After release, execution begins in FETCH.
- Outputs are Moore, decoded from state; pc_wr, ir_wr and the wait states also depend on mem_ready/zero.
- Unlisted outputs are 0 in every state.
- FETCH:
  - mem_rd=1, iord=0, alu_src_a=0, alu_src_b=01, ALUop=001.
  - When mem_ready=1: ir_wr=1, pc_wr=1, pc_src=00, go to DECODE.
  - Otherwise hold.
- DECODE:
  - alu_src_a=0, alu_src_b=11, ext_sel=1, ALUop=001 (branch target into ALUOut).
  - Next state by op: R-type (000000) → EXE_R; ori (001101) or addiu (001001) → EXE_I; lw (100011) or sw (101011) → MEM_ADR; beq (000100) → BRANCH; j (000010) → JUMP.
  - Any other op, or an R-type funct not in {100001, 100011, 101010}: illegal=1, go to FETCH.
- EXE_R: alu_src_a=1, alu_src_b=00; ALUop from funct (100001→001, 100011→101, 101010→111). → R_WB.
- R_WB: reg_dst=1, reg_wr=1, instr_done=1. → FETCH.
- EXE_I: alu_src_a=1, alu_src_b=10; ori: ext_sel=0, ALUop=010; addiu: ext_sel=1, ALUop=001. → I_WB.
- I_WB: reg_dst=0, reg_wr=1, instr_done=1. → FETCH.
- MEM_ADR: alu_src_a=1, alu_src_b=10, ext_sel=1, ALUop=001. → MEM_RD for lw, MEM_WR for sw.
- MEM_RD: iord=1, mem_rd=1; on mem_ready → MEM_WB.
- MEM_WB: mem_to_reg=1, reg_wr=1, instr_done=1. → FETCH.
- MEM_WR: iord=1, mem_wr=1; on mem_ready: instr_done=1, → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, ALUop=101, pc_src=01, pc_wr=zero, instr_done=1. → FETCH.
- JUMP: pc_src=10, pc_wr=1, instr_done=1. → FETCH.
- Wait counter:
  - Counts cycles spent in FETCH, MEM_RD or MEM_WR with mem_ready=0; cleared on every state change.
  - When it equals MEM_TIMEOUT (nonzero) and mem_ready=0: bus_err=1, go to FETCH, no ir_wr/pc_wr/reg_wr.
  - mem_ready arriving on the timeout cycle wins: normal completion, no bus_err.
- Latencies with zero-wait memory: lw 5 cycles; sw, R-type, I-type 4; beq, j 3.

Optional Feature:
- Macro CTRL_PERF_EN.
- Defined: adds outputs cycle_cnt[31:0] and instr_cnt[31:0].
  - cycle_cnt increments every cycle out of reset.
  - instr_cnt increments on instr_done.
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Shared package mc_pkg holds:
  - ALUop localparams (ALU_NOP, ALU_ADD, ALU_OR, ALU_SUB, ALU_SLT);
  - opcode and funct constants;
  - state encoding;
  - alu_src_b and pc_src encodings.
- One sub-module, mc_alu_dec: combinational funct → {ALUop, valid}, used in DECODE and EXE_R.

Test Plan:
- Reset: rst_n low mid-MEM_WR, mem_ready=0 → mem_wr falls immediately, ALUop=000; after release, FETCH with mem_rd=1 and no instr_done.
- Zero-wait subu: op=000000, funct=100011 → EXE_R shows ALUop=101; R_WB shows reg_dst=1, reg_wr=1; instr_done on cycle 4.
- beq: zero=1 in BRANCH → pc_wr=1, pc_src=01. Repeat with zero=0 → pc_wr=0, instr_done still 1.
- lw with mem_ready held low 3 cycles in MEM_RD → MEM_WB reached after the 4th MEM_RD cycle; total 8 cycles, mem_to_reg=1.
- Timeout: MEM_TIMEOUT=15, mem_ready never asserted in FETCH → bus_err pulse on the 16th FETCH cycle, re-enter FETCH, no ir_wr. Ready on that exact cycle → normal DECODE, no bus_err.
- Illegal: op=111111, then op=000000 with funct=000000 → illegal pulse in DECODE, back to FETCH, no reg_wr. With CTRL_PERF_EN, instr_cnt unchanged and cycle_cnt advancing.

Source files
------------

// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared encodings for the multi-cycle MIPS control unit
package mc_pkg;

    localparam logic [2:0] ALU_NOP = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b101;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_4      = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXE_R, S_R_WB, S_EXE_I, S_I_WB,
        S_MEM_ADR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP
    } state_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// rtl/mc_ctrl_if.sv - controller <-> datapath/memory signal bundle
interface mc_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic [2:0] ALUop;
    logic       pc_wr;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_rd;
    logic       mem_wr;
    logic       ir_wr;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_wr;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_sel;
    logic       instr_done;
    logic       illegal;
    logic       bus_err;

    modport master (
        input  op, funct, zero, mem_ready,
        output ALUop, pc_wr, pc_src, iord, mem_rd, mem_wr, ir_wr, reg_dst,
               mem_to_reg, reg_wr, alu_src_a, alu_src_b, ext_sel,
               instr_done, illegal, bus_err
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  ALUop, pc_wr, pc_src, iord, mem_rd, mem_wr, ir_wr, reg_dst,
               mem_to_reg, reg_wr, alu_src_a, alu_src_b, ext_sel,
               instr_done, illegal, bus_err
    );
endinterface

// File: rtl/mc_alu_dec.sv
// rtl/mc_alu_dec.sv - R-type funct to ALU operation decode with legality flag
module mc_alu_dec
    import mc_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] aluop,
    output logic       valid
);

    always_comb begin
        aluop = ALU_NOP;
        valid = 1'b0;
        case (funct)
            FN_ADDU: begin aluop = ALU_ADD; valid = 1'b1; end
            FN_SUBU: begin aluop = ALU_SUB; valid = 1'b1; end
            FN_SLT:  begin aluop = ALU_SLT; valid = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle MIPS control FSM; CTRL_PERF_EN adds cycle/instr counters
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mc_ctrl_if.master     bus
`ifdef CTRL_PERF_EN
    ,
    output logic [31:0]   cycle_cnt,
    output logic [31:0]   instr_cnt
`endif
);

    localparam bit               TMO_EN = (MEM_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TMO    = CNT_W'(MEM_TIMEOUT);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic             wait_st;
    logic             timeout;
    logic [2:0]       fn_aluop;
    logic             fn_valid;

    mc_alu_dec u_alu_dec (
        .funct (bus.funct),
        .aluop (fn_aluop),
        .valid (fn_valid)
    );

    assign wait_st = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    assign timeout = TMO_EN && wait_st && (wait_cnt == TMO) && !bus.mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_nxt;
    end

    // An abort re-enters FETCH without a state change, so it must clear the count too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wait_cnt <= '0;
        else if (state_nxt != state || timeout)
            wait_cnt <= '0;
        else if (wait_st && !bus.mem_ready && wait_cnt != '1)
            wait_cnt <= wait_cnt + 1'b1;
    end

    // Outputs are forced low while reset is held, even though state already reads FETCH.
    always_comb begin
        state_nxt      = state;
        bus.ALUop      = ALU_NOP;
        bus.pc_wr      = 1'b0;
        bus.pc_src     = PCSRC_ALU;
        bus.iord       = 1'b0;
        bus.mem_rd     = 1'b0;
        bus.mem_wr     = 1'b0;
        bus.ir_wr      = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.reg_wr     = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = SRCB_B;
        bus.ext_sel    = 1'b0;
        bus.instr_done = 1'b0;
        bus.illegal    = 1'b0;
        bus.bus_err    = 1'b0;
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    bus.mem_rd    = 1'b1;
                    bus.alu_src_b = SRCB_4;
                    bus.ALUop     = ALU_ADD;
                    if (bus.mem_ready) begin
                        bus.ir_wr = 1'b1;
                        bus.pc_wr = 1'b1;
                        state_nxt = S_DECODE;
                    end else if (timeout) begin
                        bus.bus_err = 1'b1;
                    end
                end
                S_DECODE: begin
                    bus.alu_src_b = SRCB_IMM_SH;
                    bus.ext_sel   = 1'b1;
                    bus.ALUop     = ALU_ADD;
                    state_nxt     = S_FETCH;
                    case (bus.op)
                        OP_RTYPE:        if (fn_valid) state_nxt = S_EXE_R;
                                         else          bus.illegal = 1'b1;
                        OP_ORI, OP_ADDIU: state_nxt = S_EXE_I;
                        OP_LW, OP_SW:     state_nxt = S_MEM_ADR;
                        OP_BEQ:           state_nxt = S_BRANCH;
                        OP_J:             state_nxt = S_JUMP;
                        default:          bus.illegal = 1'b1;
                    endcase
                end
                S_EXE_R: begin
                    bus.alu_src_a = 1'b1;
                    bus.ALUop     = fn_aluop;
                    state_nxt     = S_R_WB;
                end
                S_R_WB: begin
                    bus.reg_dst    = 1'b1;
                    bus.reg_wr     = 1'b1;
                    bus.instr_done = 1'b1;
                    state_nxt      = S_FETCH;
                end
                S_EXE_I: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = SRCB_IMM;
                    bus.ext_sel   = (bus.op != OP_ORI);
                    bus.ALUop     = (bus.op == OP_ORI) ? ALU_OR : ALU_ADD;
                    state_nxt     = S_I_WB;
                end
                S_I_WB: begin
                    bus.reg_wr     = 1'b1;
                    bus.instr_done = 1'b1;
                    state_nxt      = S_FETCH;
                end
                S_MEM_ADR: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = SRCB_IMM;
                    bus.ext_sel   = 1'b1;
                    bus.ALUop     = ALU_ADD;
                    state_nxt     = (bus.op == OP_LW) ? S_MEM_RD : S_MEM_WR;
                end
                S_MEM_RD: begin
                    bus.iord   = 1'b1;
                    bus.mem_rd = 1'b1;
                    if (bus.mem_ready) state_nxt = S_MEM_WB;
                    else if (timeout) begin
                        bus.bus_err = 1'b1;
                        state_nxt   = S_FETCH;
                    end
                end
                S_MEM_WB: begin
                    bus.mem_to_reg = 1'b1;
                    bus.reg_wr     = 1'b1;
                    bus.instr_done = 1'b1;
                    state_nxt      = S_FETCH;
                end
                S_MEM_WR: begin
                    bus.iord   = 1'b1;
                    bus.mem_wr = 1'b1;
                    if (bus.mem_ready) begin
                        bus.instr_done = 1'b1;
                        state_nxt      = S_FETCH;
                    end else if (timeout) begin
                        bus.bus_err = 1'b1;
                        state_nxt   = S_FETCH;
                    end
                end
                S_BRANCH: begin
                    bus.alu_src_a  = 1'b1;
                    bus.ALUop      = ALU_SUB;
                    bus.pc_src     = PCSRC_ALUOUT;
                    bus.pc_wr      = bus.zero;
                    bus.instr_done = 1'b1;
                    state_nxt      = S_FETCH;
                end
                S_JUMP: begin
                    bus.pc_src     = PCSRC_JUMP;
                    bus.pc_wr      = 1'b1;
                    bus.instr_done = 1'b1;
                    state_nxt      = S_FETCH;
                end
                default: state_nxt = S_FETCH;
            endcase
        end
    end

`ifdef CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (bus.instr_done) instr_cnt <= instr_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - randomized instruction stream checked against a per-instruction latency/effect model
module tb_mc_ctrl;
    import mc_pkg::*;

    localparam int C_ILL = 0, C_R = 1, C_I = 2, C_LW = 3, C_SW = 4, C_BEQ = 5, C_J = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mc_ctrl_if bus ();

`ifdef CTRL_PERF_EN
    logic [31:0] cycle_cnt, instr_cnt;
    logic [31:0] ref_cyc;
    int          ref_instr = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ref_cyc <= 32'd0;
        else        ref_cyc <= ref_cyc + 32'd1;
    end
`endif

    mc_ctrl #(.MEM_TIMEOUT(15), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus)
`ifdef CTRL_PERF_EN
        ,
        .cycle_cnt (cycle_cnt),
        .instr_cnt (instr_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] all_outs();
        return {bus.ALUop, bus.pc_wr, bus.pc_src, bus.iord, bus.mem_rd, bus.mem_wr,
                bus.ir_wr, bus.reg_dst, bus.mem_to_reg, bus.reg_wr, bus.alu_src_a,
                bus.alu_src_b, bus.ext_sel, bus.instr_done, bus.illegal, bus.bus_err};
    endfunction

    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'b000000: return (fn == 6'b100001 || fn == 6'b100011 || fn == 6'b101010) ? C_R : C_ILL;
            6'b001101, 6'b001001: return C_I;
            6'b100011: return C_LW;
            6'b101011: return C_SW;
            6'b000100: return C_BEQ;
            6'b000010: return C_J;
            default:   return C_ILL;
        endcase
    endfunction

    function automatic int r_alu(input logic [5:0] fn);
        if (fn == 6'b100001) return 1;
        if (fn == 6'b100011) return 5;
        return 7;
    endfunction

    // Runs one instruction from FETCH; fw/mw are ready-low cycles before completion (>=16 never ready).
    task automatic run_instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                             input int fw, input int mw, input logic z);
        int cls, m0, len, done_at, ill_at, err_at;
        int e_ir, e_pc, e_reg, e_rd, e_wr, e_m2r, e_dst, e_alu, e_pcsrc, e_ext;
        int n_ir, n_pc, n_reg, n_rd, n_wr, n_m2r, n_done, n_ill, n_err;
        int d_idx, i_idx, b_idx, s_dec, s_alu, s_pcsrc, s_ext, s_dst;
        bit f_to, m_to, mem;
        logic rdy;
        cls = classify(op, fn);
        f_to = (fw >= 16); m_to = (mw >= 16); mem = (cls == C_LW || cls == C_SW);
        m0 = fw + 3; done_at = -1; ill_at = -1; err_at = -1;
        e_ir = 0; e_pc = 0; e_reg = 0; e_rd = 0; e_wr = 0; e_m2r = 0; e_dst = 0;
        e_alu = 0; e_pcsrc = 0; e_ext = 0;
        if (f_to) begin
            len = 16; err_at = 15; e_rd = 16;
        end else begin
            e_ir = 1; e_pc = 1; e_rd = fw + 1;
            case (cls)
                C_ILL: begin len = fw + 2; ill_at = fw + 1; end
                C_R, C_I: begin
                    len = fw + 4; done_at = fw + 3; e_reg = 1;
                    e_dst = (cls == C_R) ? 1 : 0;
                    e_alu = (cls == C_R) ? r_alu(fn) : ((op == 6'b001101) ? 2 : 1);
                    e_ext = (cls == C_I && op != 6'b001101) ? 1 : 0;
                end
                C_BEQ: begin len = fw + 3; done_at = fw + 2; e_pc += int'(z); e_alu = 5; e_pcsrc = 1; end
                C_J:   begin len = fw + 3; done_at = fw + 2; e_pc = 2; e_pcsrc = 2; end
                default: begin
                    e_alu = 1; e_ext = 1;
                    if (m_to) begin
                        len = m0 + 16; err_at = m0 + 15;
                    end else begin
                        len = m0 + mw + 1 + ((cls == C_LW) ? 1 : 0);
                        done_at = len - 1;
                    end
                    if (cls == C_LW) begin
                        e_rd += m_to ? 16 : mw + 1;
                        e_reg = m_to ? 0 : 1; e_m2r = e_reg;
                    end else begin
                        e_wr = m_to ? 16 : mw + 1;
                    end
                end
            endcase
        end
        n_ir = 0; n_pc = 0; n_reg = 0; n_rd = 0; n_wr = 0; n_m2r = 0;
        n_done = 0; n_ill = 0; n_err = 0; d_idx = -1; i_idx = -1; b_idx = -1;
        s_dec = -1; s_alu = -1; s_pcsrc = -1; s_ext = -1; s_dst = -1;
        for (int c = 0; c < len; c++) begin
            if (f_to) rdy = 1'b0;
            else if (c <= fw) rdy = (c == fw);
            else if (mem && c >= m0 && c <= m0 + (m_to ? 15 : mw)) rdy = (!m_to && c == m0 + mw);
            else rdy = 1'($urandom_range(0, 1));
            bus.op = op; bus.funct = fn; bus.zero = z; bus.mem_ready = rdy;
            @(negedge clk);
            n_ir += int'(bus.ir_wr); n_pc += int'(bus.pc_wr); n_reg += int'(bus.reg_wr);
            n_rd += int'(bus.mem_rd); n_wr += int'(bus.mem_wr); n_m2r += int'(bus.mem_to_reg);
            if (bus.instr_done) begin n_done++; if (d_idx < 0) d_idx = c; end
            if (bus.illegal)    begin n_ill++;  if (i_idx < 0) i_idx = c; end
            if (bus.bus_err)    begin n_err++;  if (b_idx < 0) b_idx = c; end
            if (c == fw + 1) s_dec = int'(bus.ALUop);
            if (c == fw + 2) begin s_alu = int'(bus.ALUop); s_pcsrc = int'(bus.pc_src); s_ext = int'(bus.ext_sel); end
            if (bus.reg_wr) s_dst = int'(bus.reg_dst);
            @(posedge clk); #1;
        end
        check_eq({nm, ".ir_wr"},      n_ir,  e_ir);
        check_eq({nm, ".pc_wr"},      n_pc,  e_pc);
        check_eq({nm, ".reg_wr"},     n_reg, e_reg);
        check_eq({nm, ".mem_rd_cyc"}, n_rd,  e_rd);
        check_eq({nm, ".mem_wr_cyc"}, n_wr,  e_wr);
        check_eq({nm, ".mem_to_reg"}, n_m2r, e_m2r);
        check_eq({nm, ".done_at"},    d_idx, done_at);
        check_eq({nm, ".done_cnt"},   n_done, (done_at >= 0) ? 1 : 0);
        check_eq({nm, ".illegal_at"}, i_idx, ill_at);
        check_eq({nm, ".illegal_cnt"}, n_ill, (ill_at >= 0) ? 1 : 0);
        check_eq({nm, ".bus_err_at"}, b_idx, err_at);
        check_eq({nm, ".bus_err_cnt"}, n_err, (err_at >= 0) ? 1 : 0);
        if (!f_to) check_eq({nm, ".dec_aluop"}, s_dec, 1);
        if (!f_to && cls != C_ILL) begin
            check_eq({nm, ".exe_aluop"},  s_alu,   e_alu);
            check_eq({nm, ".exe_pc_src"}, s_pcsrc, e_pcsrc);
            check_eq({nm, ".exe_ext"},    s_ext,   e_ext);
        end
        if (e_reg != 0) check_eq({nm, ".reg_dst"}, s_dst, e_dst);
`ifdef CTRL_PERF_EN
        if (done_at >= 0) ref_instr++;
        check_eq({nm, ".cycle_cnt"}, int'(cycle_cnt), int'(ref_cyc));
        check_eq({nm, ".instr_cnt"}, int'(instr_cnt), ref_instr);
`endif
    endtask

    function automatic int pick_wait();
        int r;
        r = int'($urandom_range(0, 19));
        if (r < 15) return int'($urandom_range(0, 3));
        if (r < 17) return 15;
        if (r < 19) return 16;
        return 14;
    endfunction

    task automatic rand_instr(input int k);
        logic [5:0] legal_ops [7];
        logic [5:0] rfn [3];
        logic [5:0] op, fn;
        int kind;
        legal_ops = '{6'b000000, 6'b001101, 6'b001001, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
        rfn = '{6'b100001, 6'b100011, 6'b101010};
        kind = int'($urandom_range(0, 9));
        fn = 6'($urandom_range(0, 63));
        if (kind < 3) begin
            op = 6'b000000; fn = rfn[kind];
        end else if (kind < 8) begin
            op = legal_ops[kind - 2];
        end else if (kind == 8) begin
            op = 6'b000000;
            while (classify(op, fn) != C_ILL) fn = 6'($urandom_range(0, 63));
        end else begin
            op = 6'($urandom_range(0, 63));
            while (op == 6'b000000 || classify(op, fn) != C_ILL) op = 6'($urandom_range(0, 63));
        end
        if (kind == 4 + 3) op = legal_ops[5 + int'($urandom_range(0, 1))];
        run_instr($sformatf("rnd%0d", k), op, fn, pick_wait(), pick_wait(), 1'($urandom_range(0, 1)));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.op = 6'd0; bus.funct = 6'd0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
        #1;
        check_eq("reset.outs", int'(all_outs()), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // sw stalled in MEM_WR, then reset strikes mid-access
        bus.op = OP_SW; bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("rst.pre_mem_wr", int'(bus.mem_wr), 1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst.async_outs", int'(all_outs()), 0);
        check_eq("rst.async_aluop", int'(bus.ALUop), 0);
`ifdef CTRL_PERF_EN
        ref_instr = 0;
        check_eq("rst.cycle_cnt", int'(cycle_cnt), 0);
        check_eq("rst.instr_cnt", int'(instr_cnt), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        check_eq("rst.fetch_mem_rd", int'(bus.mem_rd), 1);
        check_eq("rst.no_done", int'(bus.instr_done), 0);
        check_eq("rst.no_ir_wr", int'(bus.ir_wr), 0);
        @(posedge clk); #1;

        run_instr("subu",      6'b000000, 6'b100011, 0, 0, 1'b0);
        run_instr("beq_z1",    6'b000100, 6'b000000, 0, 0, 1'b1);
        run_instr("beq_z0",    6'b000100, 6'b000000, 0, 0, 1'b0);
        run_instr("lw_w3",     6'b100011, 6'b010101, 0, 3, 1'b0);
        run_instr("fetch_to",  6'b000000, 6'b100001, 16, 0, 1'b0);
        run_instr("fetch_15",  6'b000000, 6'b100001, 15, 0, 1'b0);
        run_instr("bad_op",    6'b111111, 6'b000000, 0, 0, 1'b0);
        run_instr("bad_fn",    6'b000000, 6'b000000, 1, 0, 1'b0);
        run_instr("sw_to",     6'b101011, 6'b000000, 0, 16, 1'b0);
        run_instr("lw_15",     6'b100011, 6'b000000, 2, 15, 1'b0);
        run_instr("ori",       6'b001101, 6'b111111, 0, 0, 1'b0);
        run_instr("j",         6'b000010, 6'b000000, 2, 0, 1'b1);

        for (int k = 0; k < 80; k++) rand_instr(k);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
